// File: rtl/wm_phase_timer_pkg.sv
// Shared types and the phase-duration table for the washing-machine phase timer.
package wm_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] PH_FILL  = 2'b00;
    localparam logic [1:0] PH_WASH  = 2'b01;
    localparam logic [1:0] PH_RINSE = 2'b10;
    localparam logic [1:0] PH_DRAIN = 2'b11;

    localparam int DUR_W = 8;

    // Seconds per phase (row) and program (column); drain never runs a timer.
    localparam logic [DUR_W-1:0] DUR_TABLE [4][4] = '{
        '{8'd5,  8'd8,  8'd10, 8'd12},
        '{8'd20, 8'd30, 8'd40, 8'd60},
        '{8'd10, 8'd15, 8'd20, 8'd25},
        '{8'd0,  8'd0,  8'd0,  8'd0}
    };

    function automatic logic [DUR_W-1:0] dur_lookup(input logic [1:0] ph,
                                                     input logic [1:0] prog);
        return DUR_TABLE[ph][prog];
    endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides the system clock down to a one-second tick; freezes its count while disabled.
module wm_tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer answering the controller's start_timer/timer_done handshake.
// Optional macro WM_TIMER_BCD_EN presents remaining as two BCD digits.
module wm_phase_timer
    import wm_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int TIME_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_timer,
    input  logic              pause,
    input  logic [1:0]        phase,
    input  logic [1:0]        program_selection,
    output logic              timer_done,
    output logic              busy,
    output logic              paused,
    output logic [TIME_W-1:0] remaining
);

    state_e            state, state_next;
    logic [TIME_W-1:0] count, count_next;
    logic              active;
    logic              counting;
    logic              tick;

    assign active   = (state == RUN) || (state == PAUSED);
    // Counting also covers the PAUSED->RUN resume edge, so a pause costs exactly its length.
    assign counting = active && start_timer && !pause && (count != '0);

    wm_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (counting),
        .clear  (!active),
        .tick   (tick)
    );

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (start_timer && !pause) begin
                    state_next = RUN;
                    count_next = TIME_W'(dur_lookup(phase, program_selection));
                end
            end
            RUN, PAUSED: begin
                if (!start_timer) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == '0) begin
                    state_next = DONE;
                end else if (pause) begin
                    state_next = PAUSED;
                end else begin
                    state_next = RUN;
                    if (tick) begin
                        count_next = count - 1'b1;
                        if (count == TIME_W'(1)) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                count_next = '0;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            timer_done <= 1'b0;
            busy       <= 1'b0;
            paused     <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            timer_done <= (state_next == DONE);
            busy       <= (state_next == RUN) || (state_next == PAUSED);
            paused     <= (state_next == PAUSED);
        end
    end

`ifdef WM_TIMER_BCD_EN
    logic [TIME_W-1:0] bcd_q;
    logic [3:0]        bcd_tens;
    logic [3:0]        bcd_ones;

    // Converting count_next keeps the BCD register aligned with the binary count.
    always_comb begin
        bcd_tens = 4'd9;
        bcd_ones = 4'd9;
        if (count_next <= TIME_W'(99)) begin
            bcd_tens = 4'(count_next / TIME_W'(10));
            bcd_ones = 4'(count_next % TIME_W'(10));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= TIME_W'({bcd_tens, bcd_ones});
        end
    end

    assign remaining = bcd_q;
`else
    assign remaining = count;
`endif

endmodule

// File: tb/tb_wm_phase_timer.sv
// Self-checking bench for wm_phase_timer (TICK_DIV=4); honours WM_TIMER_BCD_EN if defined.
module tb_wm_phase_timer;

    localparam int TDIV = 4;

    logic       clk;
    logic       rst;
    logic       start_timer;
    logic       pause;
    logic [1:0] phase;
    logic [1:0] program_selection;
    logic       timer_done;
    logic       busy;
    logic       paused;
    logic [7:0] remaining;

    int total = 0;
    int bad   = 0;

    // Reference model: seconds left = duration - productive cycles / TDIV
    int m_dur, m_work, m_rem;
    bit m_active, m_held, m_fire;
    int dur_ref [4][4] = '{'{5, 8, 10, 12}, '{20, 30, 40, 60},
                           '{10, 15, 20, 25}, '{0, 0, 0, 0}};

    wm_phase_timer #(
        .TICK_DIV(TDIV),
        .TIME_W  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_timer      (start_timer),
        .pause            (pause),
        .phase            (phase),
        .program_selection(program_selection),
        .timer_done       (timer_done),
        .busy             (busy),
        .paused           (paused),
        .remaining        (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] shown(input int v);
`ifdef WM_TIMER_BCD_EN
        if (v > 99) return 8'h99;
        return 8'((v / 10) * 16 + (v % 10));
`else
        return 8'(v);
`endif
    endfunction

    task automatic model_step(input bit s, input bit p, input logic [1:0] ph,
                              input logic [1:0] pg, input bit r);
        if (r) begin
            m_active = 0; m_held = 0; m_fire = 0; m_rem = 0;
        end else if (m_fire) begin
            m_fire = 0; m_rem = 0;
        end else if (!m_active) begin
            if (s && !p) begin
                m_active = 1; m_held = 0;
                m_dur = dur_ref[ph][pg]; m_work = 0; m_rem = m_dur;
            end
        end else if (!s) begin
            m_active = 0; m_held = 0; m_rem = 0;
        end else if (m_rem == 0) begin
            m_active = 0; m_held = 0; m_fire = 1;
        end else if (p) begin
            m_held = 1;
        end else begin
            m_held = 0;
            m_work++;
            m_rem = m_dur - m_work / TDIV;
            if (m_rem == 0) begin
                m_active = 0; m_fire = 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        total++;
        assert (remaining === shown(m_rem)) else begin
            bad++;
            $error("[TB] FAIL %s remaining got=%h want=%h", tag, remaining, shown(m_rem));
        end
        total++;
        assert (timer_done === m_fire) else begin
            bad++;
            $error("[TB] FAIL %s timer_done got=%b want=%b", tag, timer_done, m_fire);
        end
        total++;
        assert (busy === m_active) else begin
            bad++;
            $error("[TB] FAIL %s busy got=%b want=%b", tag, busy, m_active);
        end
        total++;
        assert (paused === (m_active && m_held)) else begin
            bad++;
            $error("[TB] FAIL %s paused got=%b want=%b", tag, paused, m_active && m_held);
        end
    endtask

    // Drive at the falling edge, clock once, advance the model, compare at the next falling edge.
    task automatic applyStimulus(input bit s, input bit p, input logic [1:0] ph,
                                 input logic [1:0] pg, input bit r, input string tag);
        start_timer       = s;
        pause             = p;
        phase             = ph;
        program_selection = pg;
        rst               = r;
        @(posedge clk);
        model_step(s, p, ph, pg, r);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        int done_at;
        logic [1:0] ph_now;

        m_dur = 0; m_work = 0; m_rem = 0;
        m_active = 0; m_held = 0; m_fire = 0;
        start_timer = 0; pause = 0; phase = 0; program_selection = 0; rst = 1;
        @(negedge clk);

        applyStimulus(0, 0, 2'b00, 2'b00, 1, "reset0");
        applyStimulus(1, 1, 2'b01, 2'b10, 1, "reset1");

        // Fill program 0, then back-to-back into wash with start held
        applyStimulus(1, 0, 2'b00, 2'b00, 0, "fill_load");
        total++;
        assert (remaining === shown(5)) else begin
            bad++; $error("[TB] FAIL fill_first got=%h want=%h", remaining, shown(5));
        end
        for (int k = 1; k <= 26; k++) begin
            ph_now = (k >= 21) ? 2'b01 : 2'b00;
            applyStimulus(k < 26, 0, ph_now, 2'b00, 0, "fill_b2b");
            if (k == 4) begin
                total++;
                assert (remaining === shown(4)) else begin
                    bad++; $error("[TB] FAIL first_tick got=%h want=%h", remaining, shown(4));
                end
            end
            if (k == 19 || k == 20) begin
                total++;
                assert (timer_done === (k == 20)) else begin
                    bad++; $error("[TB] FAIL done_edge k=%0d got=%b want=%b", k, timer_done, k == 20);
                end
            end
            if (k == 20) begin
                total++;
                assert (busy === 1'b0) else begin
                    bad++; $error("[TB] FAIL busy_at_done got=%b want=0", busy);
                end
            end
            if (k == 22) begin
                total++;
                assert (remaining === shown(20)) else begin
                    bad++; $error("[TB] FAIL reload got=%h want=%h", remaining, shown(20));
                end
            end
        end
        applyStimulus(0, 0, 2'b00, 2'b00, 0, "idle_a");

        // Fill run aborted by dropping start_timer
        applyStimulus(1, 0, 2'b00, 2'b01, 0, "abort_load");
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(k < 8, (k == 5), 2'b00, 2'b01, 0, "abort");
        end

        // Drain phase finishes on the first RUN edge
        applyStimulus(1, 0, 2'b11, 2'($urandom_range(0, 3)), 0, "drain_load");
        applyStimulus(1, 0, 2'b11, 2'b00, 0, "drain_done");
        total++;
        assert (timer_done === 1'b1 && remaining === 8'h00) else begin
            bad++; $error("[TB] FAIL drain got=%b/%h want=1/00", timer_done, remaining);
        end
        applyStimulus(0, 0, 2'b00, 2'b00, 0, "idle_b");

        // Wash program 3 with a 10-cycle pause
        done_at = -1;
        applyStimulus(1, 0, 2'b01, 2'b11, 0, "wash_load");
        total++;
        assert (remaining === shown(60)) else begin
            bad++; $error("[TB] FAIL wash_first got=%h want=%h", remaining, shown(60));
        end
        for (int k = 1; k <= 251; k++) begin
            applyStimulus(k <= 250, (k >= 7 && k <= 16), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 0, "wash_pause");
            if (k == 4) begin
                total++;
                assert (remaining === shown(59)) else begin
                    bad++; $error("[TB] FAIL wash_tick got=%h want=%h", remaining, shown(59));
                end
            end
            if (timer_done === 1'b1 && done_at < 0) done_at = k;
        end
        total++;
        assert (done_at == 250) else begin
            bad++; $error("[TB] FAIL pause_latency got=%0d want=250", done_at);
        end

        // Reset mid-run
        applyStimulus(1, 0, 2'b10, 2'b10, 0, "rst_load");
        for (int k = 1; k <= 6; k++) applyStimulus(1, 0, 2'b10, 2'b10, 0, "rst_run");
        applyStimulus(1, 0, 2'b10, 2'b10, 1, "rst_mid");
        total++;
        assert (busy === 1'b0 && timer_done === 1'b0 && remaining === 8'h00) else begin
            bad++; $error("[TB] FAIL rst_abort got=%b%b/%h want=00/00", busy, timer_done, remaining);
        end
        applyStimulus(0, 0, 2'b00, 2'b00, 0, "idle_c");

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 5) == 0,
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 149) == 0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
